// File: rtl/sort_nxw_oet_seq.sv
// Sequential odd-even transposition sorter: one compare-exchange phase per clock
// over N lanes of W bits, with valid/ready handshakes on both sides.
module sort_nxw_oet_seq #(
    parameter int N          = 8,
    parameter int W          = 8,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 1,
    parameter int PH_W       = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic            in_descend,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  out_data,
    output logic [PH_W-1:0] out_phases
);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t          state_q, state_d;
    logic [N*W-1:0]  data_q, data_d;
    logic            desc_q, desc_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [1:0]      q_q, q_d;
    logic            out_valid_q, out_valid_d;

    logic [N*W-1:0]  phase_data;
    logic            any_swap;
    logic [W-1:0]    lo, hi;
    logic            swap;

    function automatic logic lane_gt(input logic [W-1:0] a, input logic [W-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        else             return a > b;
    endfunction

    // Pairs within one phase never overlap, so every pair reads the registered vector.
    always_comb begin
        phase_data = data_q;
        any_swap   = 1'b0;
        lo         = '0;
        hi         = '0;
        swap       = 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if ((i % 2 == 1) == ph_q[0]) begin
                lo   = data_q[i*W +: W];
                hi   = data_q[(i+1)*W +: W];
                swap = desc_q ? lane_gt(hi, lo) : lane_gt(lo, hi);
                if (swap) begin
                    phase_data[i*W +: W]     = hi;
                    phase_data[(i+1)*W +: W] = lo;
                    any_swap                 = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        desc_d      = desc_q;
        ph_d        = ph_q;
        q_d         = q_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    desc_d  = in_descend;
                    ph_d    = '0;
                    q_d     = 2'd0;
                    state_d = SORT;
                end
            end
            SORT: begin
                data_d = phase_data;
                ph_d   = ph_q + 1'b1;
                if (any_swap)         q_d = 2'd0;
                else if (q_q == 2'd2) q_d = 2'd2;
                else                  q_d = q_q + 2'd1;
                // One even plus one odd quiet phase means the vector is already ordered.
                if ((ph_q == PH_W'(N - 1)) || ((EARLY_EXIT != 0) && (q_d == 2'd2))) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            desc_q      <= 1'b0;
            ph_q        <= '0;
            q_q         <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            desc_q      <= desc_d;
            ph_q        <= ph_d;
            q_q         <= q_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = rst_n && (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_data   = data_q;
    assign out_phases = ph_q;

endmodule
